// File: rtl/vector_length_seq_pkg.sv
// Shared definitions for the vector length datapath.
//   FIXED_FRAC_BITS : fractional bits of the Q8.24 operands and result
//   SCALE_LZ_TARGET : leading-zero count the largest component is normalised to
//   FIXED_MAX       : largest representable unsigned Q8.24 result (saturation value)
//   state_e         : sequencer state encoding
//   abs_sat()       : two's complement magnitude, most-negative input clamps to FIXED_MAX
package vector_length_seq_pkg;

    localparam int unsigned FIXED_FRAC_BITS = 24;
    localparam int unsigned SCALE_LZ_TARGET = 5;
    localparam logic [31:0] FIXED_MAX       = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StAbs,
        StScale,
        StSq,
        StSqrt,
        StOut
    } state_e;

    function automatic logic [31:0] abs_sat(input logic [31:0] val);
        logic [31:0] mag;
        if (val == 32'h8000_0000) begin
            mag = FIXED_MAX;
        end else if (val[31]) begin
            mag = ~val + 32'd1;
        end else begin
            mag = val;
        end
        return mag;
    endfunction

endpackage

// File: rtl/clz32.sv
// 32-bit leading-zero counter.
//   data_i  : word to inspect
//   count_o : number of leading zeros, 0..32 (32 for an all-zero word)
module clz32 (
    input  logic [31:0] data_i,
    output logic [5:0]  count_o
);

    // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        count_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data_i[i]) begin
                count_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fixed_sqrt_seq.sv
// Iterative restoring square root, 64-bit radicand -> 32-bit root, one root bit per
// clock MSB first. The first iteration runs on the start edge straight from
// radicand_i, so done_o pulses 32 clocks after the start edge.
// Build option: VECTOR_LENGTH_ROUND_EN rounds the root to nearest (saturating at
// all-ones); otherwise the root is truncated.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   start_i    : load radicand_i and begin
//   radicand_i : unsigned radicand
//   done_o     : one-cycle pulse, root_o valid while high
//   root_o     : root (floor, or rounded when VECTOR_LENGTH_ROUND_EN is defined)
module fixed_sqrt_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] radicand_i,
    output logic        done_o,
    output logic [31:0] root_o
);

    logic [63:0] rad_q, rad_d, rad_src;
    logic [34:0] rem_q, rem_d, rem_src;
    logic [31:0] root_q, root_d, root_src;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [36:0] rem_shift, trial;

    always_comb begin
        rad_src  = start_i ? radicand_i : rad_q;
        rem_src  = start_i ? 35'd0 : rem_q;
        root_src = start_i ? 32'd0 : root_q;
        // Bring down the next two radicand bits; trial divisor is 4*root + 1.
        rem_shift = {rem_src, rad_src[63:62]};
        trial     = {3'b000, root_src, 2'b01};

        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start_i || busy_q) begin
            rad_d = {rad_src[61:0], 2'b00};
            if (rem_shift >= trial) begin
                rem_d  = 35'(rem_shift - trial);
                root_d = {root_src[30:0], 1'b1};
            end else begin
                rem_d  = 35'(rem_shift);
                root_d = {root_src[30:0], 1'b0};
            end
            if (start_i) begin
                cnt_d  = 5'd1;
                busy_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

`ifdef VECTOR_LENGTH_ROUND_EN
    // Remainder N - root^2 above root means N lies past (root + 0.5)^2.
    assign root_o = ((rem_q > {3'b000, root_q}) && !(&root_q)) ? root_q + 32'd1 : root_q;
`else
    assign root_o = root_q;
`endif

endmodule

// File: rtl/vector_length.sv
// File intentionally holds no module; the top lives in rtl/vector_length_seq.sv.

// File: rtl/vector_length_seq.sv
// Sequential Euclidean length of a 3-component signed Q8.24 vector.
// Flow: IDLE -> ABS -> SCALE -> SQ (3 clk) -> SQRT (32 clk) -> OUT -> IDLE, so
// output_valid is high in the 38th clock after the accepting edge and a new vector
// can be taken every 39 clocks. Components are normalised so the largest has 5
// leading zeros before squaring; the root is de-normalised by the same shift.
// Build option: VECTOR_LENGTH_ROUND_EN selects a rounded root (see fixed_sqrt_seq).
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   v            : {z, y, x}, each signed Q8.24
//   new_data     : v valid, taken only while ready is high
//   ready        : high in IDLE
//   r            : |v| as unsigned Q8.24, saturated to 0x7FFFFFFF, held between results
//   output_valid : one-cycle pulse marking a new r
module vector_length_seq
    import vector_length_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] v,
    input  logic        new_data,
    output logic        ready,
    output logic [31:0] r,
    output logic        output_valid
);

    state_e             state_q, state_d;
    logic [2:0][31:0]   comp_q, comp_d;
    logic [2:0][31:0]   abs_v;
    logic [31:0]        max_q, max_d, max_xy, max_all;
    logic signed [5:0]  shift_q, shift_d, shift_now;
    logic [5:0]         lz, shl_amt, shr_amt, out_rsh, out_lsh;
    logic [1:0]         sq_cnt_q, sq_cnt_d;
    logic [63:0]        acc_q, acc_d, sq_sum, out_wide;
    logic [31:0]        mul_op, out_sat, sqrt_root;
    logic signed [63:0] prod;
    logic [31:0]        r_q, r_d;
    logic               sqrt_start, sqrt_done;

    clz32 u_clz (
        .data_i  (max_q),
        .count_o (lz)
    );

    fixed_sqrt_seq u_sqrt (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (sqrt_start),
        .radicand_i (sq_sum),
        .done_o     (sqrt_done),
        .root_o     (sqrt_root)
    );

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            abs_v[i] = abs_sat(comp_q[i]);
        end
        max_xy  = (abs_v[0] > abs_v[1]) ? abs_v[0] : abs_v[1];
        max_all = (max_xy > abs_v[2]) ? max_xy : abs_v[2];
    end

    // s = lz - 5 in 6-bit two's complement; only one of the two amounts is non-zero.
    assign shift_now = lz - 6'(SCALE_LZ_TARGET);
    assign shl_amt   = shift_now[5] ? 6'd0 : shift_now;
    assign shr_amt   = shift_now[5] ? 6'(-shift_now) : 6'd0;

    // Single shared multiplier, one component per SQ cycle.
    assign mul_op = (sq_cnt_q == 2'd0) ? comp_q[0] :
                    (sq_cnt_q == 2'd1) ? comp_q[1] : comp_q[2];
    assign prod   = 64'($signed(mul_op)) * 64'($signed(mul_op));
    assign sq_sum = acc_q + prod;

    // Undo the normalisation; anything reaching bit 31 or beyond saturates.
    assign out_rsh  = shift_q[5] ? 6'd0 : shift_q;
    assign out_lsh  = shift_q[5] ? 6'(-shift_q) : 6'd0;
    assign out_wide = ({32'd0, sqrt_root} >> out_rsh) << out_lsh;
    assign out_sat  = (|out_wide[63:31]) ? FIXED_MAX : out_wide[31:0];

    always_comb begin
        state_d    = state_q;
        comp_d     = comp_q;
        max_d      = max_q;
        shift_d    = shift_q;
        sq_cnt_d   = sq_cnt_q;
        acc_d      = acc_q;
        r_d        = r_q;
        sqrt_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (new_data) begin
                    comp_d  = v;
                    state_d = StAbs;
                end
            end
            StAbs: begin
                comp_d  = abs_v;
                max_d   = max_all;
                state_d = StScale;
            end
            StScale: begin
                for (int i = 0; i < 3; i++) begin
                    comp_d[i] = 32'(($signed(comp_q[i]) >>> shr_amt) <<< shl_amt);
                end
                shift_d  = shift_now;
                acc_d    = '0;
                sq_cnt_d = 2'd0;
                state_d  = StSq;
            end
            StSq: begin
                acc_d    = sq_sum;
                sq_cnt_d = sq_cnt_q + 2'd1;
                if (sq_cnt_q == 2'd2) begin
                    // Hand the final sum over on the same edge it completes.
                    sqrt_start = 1'b1;
                    state_d    = StSqrt;
                end
            end
            StSqrt: begin
                if (sqrt_done) begin
                    r_d     = out_sat;
                    state_d = StOut;
                end
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            comp_q   <= '0;
            max_q    <= '0;
            shift_q  <= '0;
            sq_cnt_q <= '0;
            acc_q    <= '0;
            r_q      <= '0;
        end else begin
            state_q  <= state_d;
            comp_q   <= comp_d;
            max_q    <= max_d;
            shift_q  <= shift_d;
            sq_cnt_q <= sq_cnt_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
        end
    end

    assign ready        = (state_q == StIdle);
    assign output_valid = (state_q == StOut);
    assign r            = r_q;

endmodule

// File: tb/tb_vector_length_seq.sv
module tb_vector_length_seq;

    logic        clk;
    logic        rst;
    logic [95:0] v;
    logic        new_data;
    logic        ready;
    logic [31:0] r;
    logic        output_valid;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Reference: accepted vector -> result 38 clocks later, ready again one clock after.
    int unsigned cyc      = 0;
    int unsigned m_acc    = 0;
    logic        m_active = 1'b0;
    logic        m_valid  = 1'b0;
    logic [31:0] m_r      = 32'd0;
    logic [31:0] m_pend   = 32'd0;

    vector_length_seq dut (
        .clk          (clk),
        .rst          (rst),
        .v            (v),
        .new_data     (new_data),
        .ready        (ready),
        .r            (r),
        .output_valid (output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length from first principles: magnitude, normalise, integer sqrt by search, rescale.
    function automatic logic [31:0] model_len(input logic [95:0] vec);
        longint signed   c;
        longint unsigned mag[3];
        longint unsigned mx, sum, sc, lo, hi, mid, root, outv;
        int              lz, s;
        mx  = 0;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            c = longint'($signed(vec[32*i +: 32]));
            mag[i] = (c < 0) ? longint'(-c) : longint'(c);
            if (mag[i] > 64'h7FFF_FFFF) mag[i] = 64'h7FFF_FFFF;
            if (mag[i] > mx) mx = mag[i];
        end
        lz = 0;
        while (lz < 32 && !mx[31 - lz]) lz++;
        s = lz - 5;
        for (int i = 0; i < 3; i++) begin
            sc  = (s >= 0) ? (mag[i] << s) : (mag[i] >> (-s));
            sum = sum + sc * sc;
        end
        lo = 0;
        hi = 64'hFFFF_FFFF;
        while (lo < hi) begin
            mid = lo + (hi - lo + 1) / 2;
            if (mid * mid <= sum) lo = mid;
            else hi = mid - 1;
        end
        root = lo;
`ifdef VECTOR_LENGTH_ROUND_EN
        if ((sum - root * root > root) && (root != 64'hFFFF_FFFF)) root = root + 1;
`endif
        outv = (s >= 0) ? (root >> s) : (root << (-s));
        if (outv > 64'h7FFF_FFFF) outv = 64'h7FFF_FFFF;
        return outv[31:0];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_r      <= 32'd0;
        end else begin
            m_valid <= m_active && (cyc == m_acc + 37);
            if (m_active && cyc == m_acc + 37) m_r <= m_pend;
            if (m_active && cyc == m_acc + 38) m_active <= 1'b0;
            if (!m_active && new_data) begin
                m_active <= 1'b1;
                m_acc    <= cyc;
                m_pend   <= model_len(v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("ready", {31'd0, ready}, {31'd0, !m_active});
            check("output_valid", {31'd0, output_valid}, {31'd0, m_valid});
            check("r", r, m_r);
        end
    end

    task automatic send(input logic [95:0] vec);
        int n = 0;
        while (m_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_idle_wait", {31'd0, m_active}, 32'd0);
        v        = vec;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [95:0] vec, input logic [31:0] exp_r);
        int lat;
        send(vec);
        lat = 1;
        while (!output_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 32'd38);
        check({name, "_r"}, r, exp_r);
    endtask

    localparam logic [95:0] VecA = {32'h0000_0000, 32'h0400_0000, 32'h0300_0000};

    initial begin
        int nv;
        rst      = 1'b1;
        new_data = 1'b0;
        v        = '0;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_valid", {31'd0, output_valid}, 32'd0);
        check("reset_r", r, 32'd0);
        rst = 1'b0;

        run_vec("vec_3_4_0", VecA, 32'h0500_0000);
        run_vec("vec_neg_one", {64'h0, 32'hFF00_0000}, 32'h0100_0000);
        run_vec("vec_z_lsb", {32'h0000_0001, 64'h0}, 32'h0000_0001);
        run_vec("vec_zero", 96'h0, 32'h0000_0000);
        run_vec("vec_sat", {32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 32'h7FFF_FFFF);

        // Mixed signs and fractional values, checked against the model only.
        send({32'hFF40_0000, 32'h0200_0000, 32'hFE80_0000});
        send({32'h0000_0000, 32'h0000_0001, 32'h0000_0001});
        send({32'h0080_0000, 32'h0080_0000, 32'h0080_0000});
        send({32'h1234_5678, 32'hEDCB_A988, 32'h0000_0100});

        // new_data pulses while busy must be dropped.
        send(VecA);
        nv = 0;
        for (int k = 1; k <= 45; k++) begin
            new_data = (k == 5 || k == 20);
            v        = (k == 5 || k == 20) ? 96'h0 : VecA;
            if (output_valid) nv++;
            @(negedge clk);
        end
        new_data = 1'b0;
        check("busy_pulse_valid_count", nv, 32'd1);
        check("busy_pulse_r", r, 32'h0500_0000);

        // new_data held high: one vector accepted at every first ready.
        send(96'h0);
        while (m_active) @(negedge clk);
        v        = {32'h0000_0000, 32'h0000_0000, 32'hFF00_0000};
        new_data = 1'b1;
        nv = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (output_valid) nv++;
        end
        new_data = 1'b0;
        check("held_valid_count", nv, 32'd3);
        check("held_r", r, 32'h0100_0000);

        // Reset in mid-flight aborts without a result.
        send(VecA);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_r", r, 32'd0);
        check("abort_valid", {31'd0, output_valid}, 32'd0);
        rst = 1'b0;
        nv = 0;
        repeat (45) begin
            @(negedge clk);
            if (output_valid) nv++;
        end
        check("abort_no_valid", nv, 32'd0);
        run_vec("after_abort", VecA, 32'h0500_0000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/vector_length_seq.md
VECTOR_LENGTH_SEQ -- requirements
Module: vector_length_seq

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: v  input  96  vector {z[95:64], y[63:32], x[31:0]}, each signed Q8.24.
REQ-004 SHALL have port: new_data  input  1  v valid; accepted only when ready=1.
REQ-005 SHALL have port: ready  output  1  high in IDLE only.
REQ-006 SHALL have port: r  output  32  Euclidean length |v|, unsigned Q8.24 in [0, 0x7FFFFFFF].
REQ-007 SHALL have port: output_valid  output  1  one-cycle pulse marking r valid.

Function
REQ-008 SHALL use states: IDLE -> ABS -> SCALE -> SQ -> SQRT -> OUT -> IDLE.
REQ-009 IDLE: ready=1; on new_data=1, capture v and go to ABS; new_data while ready=0 SHALL be ignored, not queued.
REQ-010 ABS (1 cycle): per-component absolute value; 0x80000000 saturates to 0x7FFFFFFF; register max of the three.
REQ-011 SCALE (1 cycle): lz = leading zeros of max (0..32); s = lz-5; components arithmetic-shifted left by s if s>0, right by -s if s<0, unchanged if s=0.
REQ-012 SQ (3 cycles, one shared 32x32 signed multiplier): accumulate x'^2, y'^2, z'^2 into 64-bit unsigned accumulator (Q16.48, no overflow).
REQ-013 SQRT (32 cycles): restoring integer square root, one result bit per cycle MSB first, 64-bit radicand -> 32-bit root (Q8.24).
REQ-014 OUT (1 cycle): root shifted right by s if s>0, left by -s if s<0; any shifted-out 1 or result >0x7FFFFFFF saturates to 0x7FFFFFFF; r registered, output_valid=1.
REQ-015 Latency: output_valid SHALL assert exactly 38 clocks after the accepting edge; throughput one vector per 39 clocks; ready SHALL return high the cycle after output_valid.
REQ-016 r SHALL hold its value until the next OUT state.
REQ-017 Zero vector (lz=32) SHALL yield r=0 with normal latency.

Reset
REQ-018 On rst=1 at a clock edge: state=IDLE, r=0, output_valid=0, ready=1 on the following cycle.
REQ-019 Reset mid-operation SHALL abort silently; no output_valid for the aborted vector.

Configuration
REQ-020 Macro VECTOR_LENGTH_ROUND_EN defined: SQRT result rounded to nearest (root+1 when final remainder > root, saturating); latency unchanged.
REQ-021 Macro VECTOR_LENGTH_ROUND_EN undefined: root truncated (floor).

Structure
REQ-022 Shared package SHALL hold FIXED_FRAC_BITS=24, SCALE_LZ_TARGET=5, FIXED_MAX=32'h7FFFFFFF and the state encoding.
REQ-023 The 64->32 iterative root SHALL be sub-module fixed_sqrt_seq (start/done handshake, 32-cycle fixed latency).
REQ-024 The leading-zero count SHALL reuse the codebase's existing 32-bit clz block.

Verification
REQ-025 v=(x=0x03000000, y=0x04000000, z=0) -> r=0x05000000, output_valid exactly 38 clocks after accept.
REQ-026 v=(x=0xFF000000 (-1.0), 0, 0) -> r=0x01000000; v=(0, 0, 0x00000001) -> r=0x00000001.
REQ-027 v=0 -> r=0x00000000 with output_valid at normal latency.
REQ-028 v=(0x7FFFFFFF, 0x7FFFFFFF, 0x80000000) -> r=0x7FFFFFFF (saturated).
REQ-029 new_data pulsed at cycles +5 and +20 during busy -> ignored, exactly one output_valid; back-to-back vectors each accepted at first ready.
REQ-030 rst asserted at cycle +20 -> no output_valid, r=0, ready=1 next cycle; next vector processed correctly.
